shared_bus_arbiter: RTL and testbench
=====================================

# shared_bus_arbiter

Round-robin Wishbone arbiter that shares one downstream shared-peripheral bus between `NUM_MASTERS` `rv_core` instances, each of which exposes a `shared_*` master port. Sits between the cores' shared master ports and the shared peripheral interconnect. Grants whole bus tenures, from `cyc` rise to `cyc` fall. An optional watchdog aborts tenures whose slave never acknowledges.

## Interface
Parameters:
- `NUM_MASTERS`, 4: number of requesting cores (2..8).
- `TIMEOUT_CYCLES`, 255: stalled-strobe cycles before abort; 8-bit counter, legal range 1..255.

Ports:
- `wb_clk_i`  in  1  single clock for the whole block.
- `wb_rst_ni`  in  1  reset; synchronous, active-low.
- `m_cyc_i`  in  NUM_MASTERS  per-master cycle.
- `m_stb_i`  in  NUM_MASTERS  per-master strobe.
- `m_we_i`  in  NUM_MASTERS  per-master write enable.
- `m_sel_i`  in  4*NUM_MASTERS  byte selects; master k occupies bits [4k+3:4k].
- `m_adr_i`  in  32*NUM_MASTERS  addresses; master k occupies bits [32k+31:32k].
- `m_dat_i`  in  32*NUM_MASTERS  write data, packed as `m_adr_i`.
- `m_dat_o`  out  32*NUM_MASTERS  read data, packed as `m_adr_i`.
- `m_ack_o`  out  NUM_MASTERS  per-master acknowledge.
- `m_err_o`  out  NUM_MASTERS  per-master error, driven by timeout abort.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  downstream control.
- `s_sel_o`  out  4  downstream byte selects.
- `s_adr_o`  out  32  downstream address.
- `s_dat_o`  out  32  downstream write data.
- `s_dat_i`  in  32  downstream read data.
- `s_ack_i`  in  1  downstream acknowledge.
- `gnt_o`  out  NUM_MASTERS  one-hot registered grant; all-zero when idle.

## Operation
- Request from master k: `m_cyc_i[k] & m_stb_i[k]`.
- States:
  - IDLE: no grant.
  - BUSY: one master owns the bus.
  - ABORT: timeout fired; waiting for the owner to drop `cyc`.
- IDLE → BUSY:
  - Taken when any request is present.
  - Winner is the first requester scanning upward, modulo NUM_MASTERS, from `last+1`.
  - `last` is the index of the most recently granted master; it resets to NUM_MASTERS-1, so master 0 has first priority after reset.
- BUSY:
  - Slave outputs are combinationally muxed from the granted master.
  - `s_ack_i` and `s_dat_i` are routed only to the granted master's `m_ack_o`/`m_dat_o`.
  - All other `m_ack_o`/`m_err_o` are 0 and their `m_dat_o` slots are 0.
- BUSY → IDLE: taken when the granted master's `m_cyc_i` is 0; `last` updates to that index.
- While not BUSY:
  - `s_cyc_o`, `s_stb_o`, `s_we_o` = 0; `s_sel_o`, `s_adr_o`, `s_dat_o` = 0.
  - All `m_ack_o`, `m_err_o`, `m_dat_o` = 0.
- Masters not granted are stalled simply by never seeing `ack`; the arbiter does not queue anything.
- Reset (`wb_rst_ni` = 0 at a clock edge):
  - Aborts any tenure: state IDLE, `gnt_o` = 0, `last` = NUM_MASTERS-1, timeout counter 0.
  - The slave sees `cyc` drop in the cycle after the reset edge.

## Timing
- Arbitration latency:
  - Request seen in cycle n → `gnt_o` and the slave bus are valid from cycle n+1.
  - Ack passes back with zero added latency (combinational).
- Tenure release: `cyc` low in cycle n → IDLE in n+1 → earliest new grant effective in n+2. There is one dead cycle between tenures.
- Simultaneous requests: resolved purely by the rotating priority. A master requesting while another is granted waits for release.
- Multiple strobes in one tenure (`cyc` held high): no re-arbitration.

## Configuration
- `SHARED_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on grant and on every `s_ack_i`, and increments each BUSY cycle with `s_stb_o` = 1 and `s_ack_i` = 0.
  - When the counter reaches TIMEOUT_CYCLES, `m_err_o[k]` pulses for exactly one cycle, `s_cyc_o`/`s_stb_o` drop in that same cycle, and the state goes to ABORT.
  - ABORT → IDLE when `m_cyc_i[k]` = 0.
- Not defined:
  - No counter and no ABORT state.
  - `m_err_o` is tied to 0.
  - A hung slave holds the bus indefinitely.

## Structure
- Shared package `shared_arb_pkg` holds:
  - state encoding (IDLE=2'd0, BUSY=2'd1, ABORT=2'd2);
  - localparam for counter width 8.
- One sub-module, `rr_picker`: combinational round-robin selector, inputs request vector and `last`, outputs one-hot winner and its index. It is reusable by other shared-resource arbiters.

## Test plan
- Reset, then master 2 alone reads 0x3000_0010 while the slave acks after 3 cycles with 0xDEAD_BEEF: `gnt_o` = 4'b0100 one cycle after the request; `m_dat_o` slot 2 = 0xDEAD_BEEF with `m_ack_o` = 4'b0100; IDLE one cycle after `cyc` drops.
- Masters 0–3 request simultaneously and continuously, each tenure one single-ack write: grant order is 0,1,2,3,0; one dead cycle between grants; no master starves.
- Master 1 holds `cyc` across 3 strobes while master 0 requests: master 0 is granted only after master 1 drops `cyc`. Slave `adr`, `dat` and `sel` track master 1 exclusively during its tenure.
- Non-granted master 3 asserts `stb` while the slave acks master 0: `m_ack_o[3]` = 0 and its `m_dat_o` slot = 0.
- With `SHARED_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=4, master 0 reads and the slave never acks: `m_err_o[0]` pulses in the 4th stalled cycle and `s_cyc_o` falls in that same cycle; master 1 is granted once master 0 drops `cyc`.
- Assert `wb_rst_ni` = 0 mid-tenure: next cycle `s_cyc_o` = 0 and `gnt_o` = 0; the first grant after reset release goes to master 0 when all masters request.

Source files
------------

// File: rtl/shared_arb_pkg.sv
// Shared definitions for the shared-bus arbiter: FSM encoding and watchdog counter width.
package shared_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_t;

  // Width of the stalled-strobe watchdog counter.
  localparam int CNT_W = 8;

endpackage

// File: rtl/shared_bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector. Scans upward from last+1
// (modulo N) and returns the first requester as a one-hot vector and an index.
// Reusable by any shared-resource arbiter.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int          cand;
  logic [IW-1:0] cand_idx;

  // First requester after 'last' wins; 'last' itself is checked last.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= N; i++) begin
      cand     = (int'(last) + i) % N;
      cand_idx = cand[IW-1:0];
      if (!valid && req[cand_idx]) begin
        valid         = 1'b1;
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/shared_bus_arbiter.sv
// shared_bus_arbiter: round-robin Wishbone arbiter granting whole tenures
// (cyc rise to cyc fall) of one downstream bus to NUM_MASTERS masters.
// Optional watchdog abort of stalled strobes: define SHARED_ARB_TIMEOUT_EN.
//
// Handshake: a master requests with cyc&stb; it owns the bus from the cycle
// after the grant until it drops cyc. Every strobe of the owner completes when
// the slave's ack (passed back combinationally) is seen; non-owners simply
// never see ack. A watchdog abort completes the strobe with err instead.
module shared_bus_arbiter
  import shared_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
  input  logic [32*NUM_MASTERS-1:0] m_adr_i,
  input  logic [32*NUM_MASTERS-1:0] m_dat_i,
  output logic [32*NUM_MASTERS-1:0] m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [3:0]                s_sel_o,
  output logic [31:0]               s_adr_o,
  output logic [31:0]               s_dat_o,
  input  logic [31:0]               s_dat_i,
  input  logic                      s_ack_i,
  output logic [NUM_MASTERS-1:0]    gnt_o,
  output arb_state_t                state_o
);

  localparam int IW = $clog2(NUM_MASTERS);

  arb_state_t             state;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic [IW-1:0]          own_idx;
  logic [IW-1:0]          last_idx;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   busy;
  logic                   timeout_hit;

  assign req     = m_cyc_i & m_stb_i;
  assign busy    = (state == ST_BUSY);
  assign gnt_o   = gnt_q;
  assign state_o = state;

  rr_picker #(.N(NUM_MASTERS), .IW(IW)) u_picker (
    .req   (req),
    .last  (last_idx),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

`ifdef SHARED_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             own_stb;

  assign own_stb = m_cyc_i[own_idx] & m_stb_i[own_idx];

  // The abort fires in the stalled cycle that brings the count to TIMEOUT_CYCLES;
  // own_stb (not s_stb_o) is used so the abort does not feed back on itself.
  assign timeout_hit = busy & own_stb & ~s_ack_i & (tmo_cnt == TMO_LAST);

  // Count stalled strobe cycles of the owner; cleared outside BUSY and on every ack.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      tmo_cnt <= '0;
    end else if (!busy || s_ack_i) begin
      tmo_cnt <= '0;
    end else if (own_stb) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Single-cycle error pulse to the owner when the watchdog fires.
  always_comb begin
    m_err_o = '0;
    if (timeout_hit) m_err_o[own_idx] = 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
  assign m_err_o     = '0;
`endif

  // Arbitration FSM: grant on any request, hold until the owner drops cyc.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state    <= ST_IDLE;
      gnt_q    <= '0;
      own_idx  <= '0;
      last_idx <= IW'(NUM_MASTERS - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state   <= ST_BUSY;
            gnt_q   <= pick_gnt;
            own_idx <= pick_idx;
          end
        end
        ST_BUSY: begin
          if (!m_cyc_i[own_idx]) begin
            state    <= ST_IDLE;
            gnt_q    <= '0;
            last_idx <= own_idx;
          end else if (timeout_hit) begin
            state <= ST_ABORT;
          end
        end
`ifdef SHARED_ARB_TIMEOUT_EN
        ST_ABORT: begin
          if (!m_cyc_i[own_idx]) begin
            state    <= ST_IDLE;
            gnt_q    <= '0;
            last_idx <= own_idx;
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
          gnt_q <= '0;
        end
      endcase
    end
  end

  // Route the owner to the slave and the slave response back to the owner only.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    m_ack_o = '0;
    m_dat_o = '0;
    if (busy) begin
      s_cyc_o = m_cyc_i[own_idx] & ~timeout_hit;
      s_stb_o = m_stb_i[own_idx] & ~timeout_hit;
      s_we_o  = m_we_i[own_idx];
      s_sel_o = m_sel_i[4*own_idx +: 4];
      s_adr_o = m_adr_i[32*own_idx +: 32];
      s_dat_o = m_dat_i[32*own_idx +: 32];
      m_ack_o[own_idx]            = s_ack_i;
      m_dat_o[32*own_idx +: 32]   = s_dat_i;
    end
  end

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter (4 masters, TIMEOUT_CYCLES = 4).
// The watchdog scenario runs only when SHARED_ARB_TIMEOUT_EN is defined.
module tb_shared_bus_arbiter;
  import shared_arb_pkg::*;

  localparam int NM = 4;

  // ---------------- clock / reset ----------------
  logic wb_clk_i = 1'b0;
  logic wb_rst_ni = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  logic [NM-1:0]    m_cyc, m_stb, m_we;
  logic [4*NM-1:0]  m_sel;
  logic [32*NM-1:0] m_adr, m_dat_w;
  logic [32*NM-1:0] m_dat_o;
  logic [NM-1:0]    m_ack_o, m_err_o;
  logic             s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]       s_sel_o;
  logic [31:0]      s_adr_o, s_dat_o;
  logic [31:0]      s_dat_i;
  logic             s_ack_i;
  logic [NM-1:0]    gnt_o;
  arb_state_t       state_o;

  shared_bus_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(4)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_ni(wb_rst_ni),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_we_i   (m_we),
    .m_sel_i  (m_sel),
    .m_adr_i  (m_adr),
    .m_dat_i  (m_dat_w),
    .m_dat_o  (m_dat_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_sel_o  (s_sel_o),
    .s_adr_o  (s_adr_o),
    .s_dat_o  (s_dat_o),
    .s_dat_i  (s_dat_i),
    .s_ack_i  (s_ack_i),
    .gnt_o    (gnt_o),
    .state_o  (state_o)
  );

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_master(input int k, input logic cyc, input logic stb, input logic we,
                              input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    m_cyc[k]           = cyc;
    m_stb[k]           = stb;
    m_we[k]            = we;
    m_sel[4*k +: 4]    = sel;
    m_adr[32*k +: 32]  = adr;
    m_dat_w[32*k +: 32] = dat;
  endtask

  task automatic idle_master(input int k);
    drive_master(k, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic next_cycle();
    @(negedge wb_clk_i);
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [31:0] slot(input logic [32*NM-1:0] v, input int k);
    return v[32*k +: 32];
  endfunction

  // Hard stop if the sequence somehow stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int order[5];
    logic [3:0]  sel_tab[3];
    logic [31:0] adr_v, dat_v, got;
    logic [3:0]  sel_v;
    order   = '{0, 1, 2, 3, 0};
    sel_tab = '{4'hF, 4'h3, 4'hC};

    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat_w = '0;
    s_ack_i = 1'b0; s_dat_i = '0;

    // ---- reset state ----
    repeat (3) next_cycle();
    settle();
    check("rst_gnt", 64'(gnt_o), 64'h0);
    check("rst_scyc", 64'(s_cyc_o), 64'h0);
    check("rst_state", 64'(state_o), 64'(ST_IDLE));
    check("rst_ack", 64'(m_ack_o), 64'h0);
    wb_rst_ni = 1'b1;

    // ---- master 2 alone reads, slave acks in its third bus cycle ----
    next_cycle();
    drive_master(2, 1'b1, 1'b1, 1'b0, 4'hF, 32'h3000_0010, 32'h0);
    exp_q.push_back(32'hDEAD_BEEF);
    settle();
    check("t1_gnt_req_cycle", 64'(gnt_o), 64'h0);
    next_cycle(); settle();
    check("t1_gnt", 64'(gnt_o), 64'b0100);
    check("t1_scyc", 64'(s_cyc_o), 64'h1);
    check("t1_sadr", 64'(s_adr_o), 64'h3000_0010);
    check("t1_swe", 64'(s_we_o), 64'h0);
    check("t1_stall1_ack", 64'(m_ack_o), 64'h0);
    next_cycle(); settle();
    check("t1_stall2_ack", 64'(m_ack_o), 64'h0);
    next_cycle();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    settle();
    check("t1_ack", 64'(m_ack_o), 64'b0100);
    got = exp_q.pop_front();
    check("t1_dat2", 64'(slot(m_dat_o, 2)), 64'(got));
    check("t1_dat0", 64'(slot(m_dat_o, 0)), 64'h0);
    next_cycle();
    s_ack_i = 1'b0; s_dat_i = '0;
    idle_master(2);
    settle();
    check("t1_rel_scyc", 64'(s_cyc_o), 64'h0);
    check("t1_rel_state", 64'(state_o), 64'(ST_BUSY));
    next_cycle(); settle();
    check("t1_idle_state", 64'(state_o), 64'(ST_IDLE));
    check("t1_idle_gnt", 64'(gnt_o), 64'h0);

    // ---- reset mid-tenure (last = 2, so master 1 wins alone) ----
    next_cycle();
    drive_master(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h3000_0020, 32'h0);
    next_cycle(); settle();
    check("rmt_gnt", 64'(gnt_o), 64'b0010);
    next_cycle();
    wb_rst_ni = 1'b0;
    settle();
    check("rmt_scyc_before_edge", 64'(s_cyc_o), 64'h1);
    next_cycle(); settle();
    check("rmt_scyc", 64'(s_cyc_o), 64'h0);
    check("rmt_gnt_clr", 64'(gnt_o), 64'h0);
    wb_rst_ni = 1'b1;

    // ---- all four masters write continuously: order 0,1,2,3,0 ----
    for (int k = 0; k < NM; k++) begin
      drive_master(k, 1'b1, 1'b1, 1'b1, 4'hF, 32'h4000_0000 + 32'(16 * k), 32'hA000_0000 + 32'(k));
      exp_q.push_back(32'hA000_0000 + 32'(k));
    end
    settle();
    check("rr_gnt_idle", 64'(gnt_o), 64'h0);
    for (int t = 0; t < 5; t++) begin
      next_cycle(); settle();
      check("rr_gnt", 64'(gnt_o), 64'(4'b0001 << order[t]));
      check("rr_swe", 64'(s_we_o), 64'h1);
      got = exp_q.pop_front();
      check("rr_sdat", 64'(s_dat_o), 64'(got));
      s_ack_i = 1'b1;
      settle();
      check("rr_ack", 64'(m_ack_o), 64'(4'b0001 << order[t]));
      next_cycle();
      s_ack_i = 1'b0;
      if (t == 4) begin
        for (int k = 0; k < NM; k++) idle_master(k);
      end else begin
        idle_master(order[t]);
      end
      settle();
      check("rr_rel_scyc", 64'(s_cyc_o), 64'h0);
      next_cycle();
      settle();
      check("rr_dead_gnt", 64'(gnt_o), 64'h0);
      check("rr_dead_state", 64'(state_o), 64'(ST_IDLE));
      if (t < 4) begin
        drive_master(order[t], 1'b1, 1'b1, 1'b1, 4'hF,
                     32'h4000_0000 + 32'(16 * order[t]), 32'hA000_0000 + 32'(order[t]));
        exp_q.push_back(32'hA000_0000 + 32'(order[t]));
      end
    end
    // Masters 1..3 still had a request queued when they were dropped.
    exp_q.delete();

    // ---- master 1 holds cyc over three strobes while master 0 waits ----
    next_cycle();
    drive_master(1, 1'b1, 1'b1, 1'b1, 4'hF, 32'h2000_0000, 32'h0);
    next_cycle(); settle();
    check("hold_gnt1", 64'(gnt_o), 64'b0010);
    drive_master(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h5000_0000, 32'h0);
    for (int s = 0; s < 3; s++) begin
      next_cycle();
      sel_v = sel_tab[s];
      adr_v = 32'h2000_0000 + 32'(4 * s);
      dat_v = $urandom;
      drive_master(1, 1'b1, 1'b1, 1'b1, sel_v, adr_v, dat_v);
      s_ack_i = 1'b1;
      settle();
      check("hold_sadr", 64'(s_adr_o), 64'(adr_v));
      check("hold_sdat", 64'(s_dat_o), 64'(dat_v));
      check("hold_ssel", 64'(s_sel_o), 64'(sel_v));
      check("hold_ack", 64'(m_ack_o), 64'b0010);
      next_cycle();
      s_ack_i = 1'b0;
      drive_master(1, 1'b1, 1'b0, 1'b1, sel_v, adr_v, dat_v);
      settle();
      check("hold_gap_gnt", 64'(gnt_o), 64'b0010);
      check("hold_gap_sstb", 64'(s_stb_o), 64'h0);
    end
    next_cycle();
    idle_master(1);
    settle();
    check("hold_rel_gnt", 64'(gnt_o), 64'b0010);
    next_cycle(); settle();
    check("hold_dead_gnt", 64'(gnt_o), 64'h0);
    next_cycle(); settle();
    check("hold_gnt0", 64'(gnt_o), 64'b0001);

    // ---- non-granted master 3 strobes while master 0 is acked ----
    drive_master(3, 1'b1, 1'b1, 1'b0, 4'hF, 32'h7000_0000, 32'h0);
    exp_q.push_back(32'h5555_AAAA);
    s_ack_i = 1'b1; s_dat_i = 32'h5555_AAAA;
    settle();
    check("ng_ack", 64'(m_ack_o), 64'b0001);
    got = exp_q.pop_front();
    check("ng_dat0", 64'(slot(m_dat_o, 0)), 64'(got));
    check("ng_dat3", 64'(slot(m_dat_o, 3)), 64'h0);
    check("ng_err", 64'(m_err_o), 64'h0);
    next_cycle();
    s_ack_i = 1'b0; s_dat_i = '0;
    idle_master(0); idle_master(3);
    next_cycle(); settle();
    check("ng_idle", 64'(state_o), 64'(ST_IDLE));

`ifdef SHARED_ARB_TIMEOUT_EN
    // ---- watchdog: master 0 reads, slave never acks ----
    next_cycle();
    drive_master(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h6000_0000, 32'h0);
    next_cycle();
    drive_master(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h6000_0100, 32'h0);
    settle();
    check("to_gnt0", 64'(gnt_o), 64'b0001);
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) begin next_cycle(); settle(); end
      check("to_err_early", 64'(m_err_o), 64'h0);
      check("to_scyc_early", 64'(s_cyc_o), 64'h1);
    end
    next_cycle(); settle();
    check("to_err", 64'(m_err_o), 64'b0001);
    check("to_scyc", 64'(s_cyc_o), 64'h0);
    check("to_sstb", 64'(s_stb_o), 64'h0);
    next_cycle();
    idle_master(0);
    settle();
    check("to_err_once", 64'(m_err_o), 64'h0);
    check("to_abort", 64'(state_o), 64'(ST_ABORT));
    next_cycle(); settle();
    check("to_idle", 64'(state_o), 64'(ST_IDLE));
    next_cycle(); settle();
    check("to_gnt1", 64'(gnt_o), 64'b0010);
    next_cycle();
    idle_master(1);
    repeat (2) next_cycle();
`endif

    // ---- final report ----
    settle();
    check("sb_empty", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
